// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup and issue signals of the ALU issue queue.
// master drives dispatch/CDB/flush and consumes issue; slave is the queue.
interface alu_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             disp_valid;
    logic             disp_ready;
    logic [6:0]       disp_opcode;
    logic [2:0]       disp_funct3;
    logic [6:0]       disp_funct7;
    logic [TAG_W-1:0] disp_rob_tag;
    logic [31:0]      disp_a_val;
    logic             disp_a_rdy;
    logic [TAG_W-1:0] disp_a_tag;
    logic [31:0]      disp_b_val;
    logic             disp_b_rdy;
    logic [TAG_W-1:0] disp_b_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             iss_valid;
    logic             iss_ready;
    logic [31:0]      iss_val_a;
    logic [31:0]      iss_val_b;
    logic [6:0]       iss_opcode;
    logic [2:0]       iss_funct3;
    logic [6:0]       iss_funct7;
    logic [TAG_W-1:0] iss_rob_tag;
    logic             flush;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_rob_tag,
               disp_a_val, disp_a_rdy, disp_a_tag, disp_b_val, disp_b_rdy, disp_b_tag,
               cdb_valid, cdb_tag, cdb_value, iss_ready, flush,
        input  disp_ready, iss_valid, iss_val_a, iss_val_b, iss_opcode, iss_funct3,
               iss_funct7, iss_rob_tag, occupancy
    );

    modport slave (
        input  disp_valid, disp_opcode, disp_funct3, disp_funct7, disp_rob_tag,
               disp_a_val, disp_a_rdy, disp_a_tag, disp_b_val, disp_b_rdy, disp_b_tag,
               cdb_valid, cdb_tag, cdb_value, iss_ready, flush,
        output disp_ready, iss_valid, iss_val_a, iss_val_b, iss_opcode, iss_funct3,
               iss_funct7, iss_rob_tag, occupancy
    );
endinterface

// File: rtl/alu_issue_queue.sv
// ALU issue queue with CDB wakeup; ALU_IQ_OLDEST_FIRST_EN selects oldest-first issue, else lowest-index.
// Latency 1 cycle dispatch/wakeup to iss_valid; disp_ready low when full, selection held while iss_ready low.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_queue_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [31:0]      val;
    } opnd_t;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [TAG_W-1:0] rob_tag;
        opnd_t            a;
        opnd_t            b;
    } entry_t;

    logic [DEPTH-1:0] vld_q, vld_d;
    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [DEPTH-1:0] elig;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             sel_found;
    logic [OCC_W-1:0] occ;
    logic             iss_vld, iss_fire, disp_fire;
    opnd_t            disp_a, disp_b;

    function automatic opnd_t wake(input opnd_t o, input logic cv,
                                   input logic [TAG_W-1:0] ct, input logic [31:0] cval);
        opnd_t r;
        r = o;
        if (cv && !o.rdy && (o.tag == ct)) begin
            r.rdy = 1'b1;
            r.val = cval;
        end
        return r;
    endfunction

    always_comb begin
        occ      = '0;
        free_idx = '0;
        elig     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            occ = occ + OCC_W'(vld_q[i]);
            if (!vld_q[i]) free_idx = IDX_W'(i);
            elig[i] = vld_q[i] && ent_q[i].a.rdy && ent_q[i].b.rdy;
        end
    end

    assign sel_found      = |elig;
    assign iss_vld        = sel_found && !bus.flush;
    assign iss_fire       = iss_vld && bus.iss_ready;
    assign bus.disp_ready = (occ < OCC_W'(DEPTH));
    assign disp_fire      = bus.disp_valid && bus.disp_ready && !bus.flush;
    assign bus.occupancy  = occ;
    assign bus.iss_valid  = iss_vld;
    assign disp_a         = '{rdy: bus.disp_a_rdy, tag: bus.disp_a_tag, val: bus.disp_a_val};
    assign disp_b         = '{rdy: bus.disp_b_rdy, tag: bus.disp_b_tag, val: bus.disp_b_val};

`ifdef ALU_IQ_OLDEST_FIRST_EN
    // age_q[j][i] set means entry j was dispatched before entry i.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];
    logic             beaten;

    always_comb begin
        sel_idx = '0;
        beaten  = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            beaten = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                if (j != i && elig[j] && age_q[j][i]) beaten = 1'b1;
            if (elig[i] && !beaten) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
        if (disp_fire) begin
            for (int j = 0; j < DEPTH; j++) age_d[j][free_idx] = vld_q[j];
            age_d[free_idx] = '0;
        end
        if (bus.flush)
            for (int i = 0; i < DEPTH; i++) age_d[i] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end
`else
    // A stalled selection is pinned so a later dispatch into a lower slot cannot steal it.
    logic             hold_q, hold_d;
    logic [IDX_W-1:0] hold_idx_q;

    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (elig[i]) sel_idx = IDX_W'(i);
        if (hold_q) sel_idx = hold_idx_q;
    end

    assign hold_d = iss_vld && !bus.iss_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_idx_q <= sel_idx;
        end
    end
`endif

    always_comb begin
        bus.iss_val_a   = '0;
        bus.iss_val_b   = '0;
        bus.iss_opcode  = '0;
        bus.iss_funct3  = '0;
        bus.iss_funct7  = '0;
        bus.iss_rob_tag = '0;
        if (iss_vld) begin
            bus.iss_val_a   = ent_q[sel_idx].a.val;
            bus.iss_val_b   = ent_q[sel_idx].b.val;
            bus.iss_opcode  = ent_q[sel_idx].opcode;
            bus.iss_funct3  = ent_q[sel_idx].funct3;
            bus.iss_funct7  = ent_q[sel_idx].funct7;
            bus.iss_rob_tag = ent_q[sel_idx].rob_tag;
        end
    end

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i]   = ent_q[i];
            ent_d[i].a = wake(ent_q[i].a, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            ent_d[i].b = wake(ent_q[i].b, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
        if (iss_fire) vld_d[sel_idx] = 1'b0;
        if (disp_fire) begin
            vld_d[free_idx]         = 1'b1;
            ent_d[free_idx].opcode  = bus.disp_opcode;
            ent_d[free_idx].funct3  = bus.disp_funct3;
            ent_d[free_idx].funct7  = bus.disp_funct7;
            ent_d[free_idx].rob_tag = bus.disp_rob_tag;
            ent_d[free_idx].a       = wake(disp_a, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
            ent_d[free_idx].b       = wake(disp_b, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        end
        if (bus.flush) vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: expected issues queued at dispatch, popped by an issue monitor.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [6:0]       op;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    alu_issue_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();
    alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.iss_valid && bus.iss_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_issue: unexpected issue of tag %0d, none expected", bus.iss_rob_tag);
            end else begin
                e = sb.pop_front();
                if (bus.iss_rob_tag !== e.tag || bus.iss_val_a !== e.a ||
                    bus.iss_val_b !== e.b || bus.iss_opcode !== e.op) begin
                    miscompares++;
                    $display("FAIL sb_issue: got tag=%0d a=%h b=%h op=%b, expected tag=%0d a=%h b=%h op=%b",
                             bus.iss_rob_tag, bus.iss_val_a, bus.iss_val_b, bus.iss_opcode,
                             e.tag, e.a, e.b, e.op);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [TAG_W-1:0] rt, input logic [6:0] op,
                            input logic [31:0] av, input logic ar, input logic [TAG_W-1:0] at,
                            input logic [31:0] bv, input logic br, input logic [TAG_W-1:0] bt);
        bus.disp_valid   = 1'b1;
        bus.disp_rob_tag = rt;
        bus.disp_opcode  = op;
        bus.disp_funct3  = 3'b000;
        bus.disp_funct7  = 7'b0000000;
        bus.disp_a_val   = av;
        bus.disp_a_rdy   = ar;
        bus.disp_a_tag   = at;
        bus.disp_b_val   = bv;
        bus.disp_b_rdy   = br;
        bus.disp_b_tag   = bt;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_value = v;
    endtask

    task automatic push_exp(input logic [TAG_W-1:0] t, input logic [31:0] a,
                            input logic [31:0] b, input logic [6:0] op);
        exp_t e;
        e.tag = t; e.a = a; e.b = b; e.op = op;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.occupancy !== 3'd0 || bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: occ=%0d iss_valid=%b disp_ready=%b, need 0/0/1",
                     bus.occupancy, bus.iss_valid, bus.disp_ready);
        end
        vectors++;
        if (bus.iss_val_a !== 32'd0 || bus.iss_val_b !== 32'd0 || bus.iss_rob_tag !== '0 ||
            bus.iss_opcode !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_payload: a=%h b=%h tag=%0d op=%b, need all zero",
                     bus.iss_val_a, bus.iss_val_b, bus.iss_rob_tag, bus.iss_opcode);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ready_dispatch();
        bus.iss_ready = 1'b1;
        set_disp(4'd1, OP_ADDI, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0);
        push_exp(4'd1, 32'd5, 32'd7, OP_ADDI);
        step();
        idle();
        vectors++;
        if (bus.iss_valid !== 1'b1 || bus.iss_val_a !== 32'd5 || bus.iss_val_b !== 32'd7 ||
            bus.iss_opcode !== OP_ADDI) begin
            miscompares++;
            $display("FAIL ready_latency: valid=%b a=%0d b=%0d op=%b, need 1/5/7/0010011",
                     bus.iss_valid, bus.iss_val_a, bus.iss_val_b, bus.iss_opcode);
        end
        step();
        vectors++;
        if (bus.occupancy !== 3'd0 || bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_free: occ=%0d valid=%b, need 0/0", bus.occupancy, bus.iss_valid);
        end
    endtask

    task automatic test_wakeup();
        bus.iss_ready = 1'b1;
        set_disp(4'd2, OP_ADD, 32'd0, 1'b0, 4'd3, 32'd2, 1'b1, 4'd0);
        push_exp(4'd2, 32'h10, 32'd2, OP_ADD);
        step();
        idle();
        set_cdb(4'd5, 32'hDEAD);
        vectors++;
        if (bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_not_ready: valid=%b, need 0", bus.iss_valid);
        end
        step();
        vectors++;
        if (bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_no_match: valid=%b after tag 5 broadcast, need 0", bus.iss_valid);
        end
        set_cdb(4'd3, 32'h10);
        step();
        idle();
        vectors++;
        if (bus.iss_valid !== 1'b1 || bus.iss_val_a !== 32'h10) begin
            miscompares++;
            $display("FAIL wake_latency: valid=%b a=%h, need 1/00000010", bus.iss_valid, bus.iss_val_a);
        end
        step();
    endtask

    task automatic test_same_cycle_capture();
        bus.iss_ready = 1'b1;
        set_disp(4'd9, OP_ADD, 32'd0, 1'b0, 4'd9, 32'd1, 1'b1, 4'd0);
        set_cdb(4'd9, 32'hAB);
        push_exp(4'd9, 32'hAB, 32'd1, OP_ADD);
        step();
        idle();
        vectors++;
        if (bus.iss_valid !== 1'b1 || bus.iss_val_a !== 32'hAB) begin
            miscompares++;
            $display("FAIL same_cycle_capture: valid=%b a=%h, need 1/000000ab", bus.iss_valid, bus.iss_val_a);
        end
        step();
    endtask

    task automatic test_full_backpressure();
        bus.iss_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(TAG_W'(4 + i), OP_ADD, 32'(100 + i), 1'b1, 4'd0, 32'(200 + i), 1'b1, 4'd0);
            push_exp(TAG_W'(4 + i), 32'(100 + i), 32'(200 + i), OP_ADD);
            step();
        end
        idle();
        vectors++;
        if (bus.disp_ready !== 1'b0 || bus.occupancy !== 3'd4) begin
            miscompares++;
            $display("FAIL full_state: disp_ready=%b occ=%0d, need 0/4", bus.disp_ready, bus.occupancy);
        end
        step();
        step();
        vectors++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_tag !== 4'd4 || bus.iss_val_a !== 32'd100) begin
            miscompares++;
            $display("FAIL stall_hold: valid=%b tag=%0d a=%0d, need 1/4/100",
                     bus.iss_valid, bus.iss_rob_tag, bus.iss_val_a);
        end
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        vectors++;
        if (bus.occupancy !== 3'd3 || bus.disp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_one: occ=%0d disp_ready=%b, need 3/1", bus.occupancy, bus.disp_ready);
        end
        bus.iss_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        vectors++;
        if (bus.occupancy !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_all: occ=%0d, need 0", bus.occupancy);
        end
    endtask

    task automatic test_back_to_back();
        bus.iss_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_disp(TAG_W'(8 + i), OP_ADDI, 32'(i * 3), 1'b1, 4'd0, 32'(i + 40), 1'b1, 4'd0);
            push_exp(TAG_W'(8 + i), 32'(i * 3), 32'(i + 40), OP_ADDI);
            step();
            vectors++;
            if (bus.occupancy !== 3'd1) begin
                miscompares++;
                $display("FAIL b2b_occ[%0d]: occ=%0d, need 1", i, bus.occupancy);
            end
        end
        idle();
        step();
        vectors++;
        if (bus.occupancy !== 3'd0) begin
            miscompares++;
            $display("FAIL b2b_drain: occ=%0d, need 0", bus.occupancy);
        end
    endtask

    task automatic test_ordering();
        logic [TAG_W-1:0] first_tag, second_tag;
`ifdef ALU_IQ_OLDEST_FIRST_EN
        first_tag = 4'd1; second_tag = 4'd2;
`else
        first_tag = 4'd2; second_tag = 4'd1;
`endif
        bus.iss_ready = 1'b0;
        set_disp(4'd10, OP_ADD, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
        step();
        set_disp(4'd11, OP_ADD, 32'd0, 1'b0, 4'd14, 32'd3, 1'b1, 4'd0);
        step();
        set_disp(4'd1, OP_ADD, 32'd0, 1'b0, 4'd12, 32'd4, 1'b1, 4'd0);
        step();
        idle();
        push_exp(4'd10, 32'd1, 32'd2, OP_ADD);
        bus.iss_ready = 1'b1;
        step();
        bus.iss_ready = 1'b0;
        set_disp(4'd2, OP_ADD, 32'd0, 1'b0, 4'd12, 32'd5, 1'b1, 4'd0);
        step();
        idle();
        set_cdb(4'd12, 32'h55);
        step();
        idle();
        vectors++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rob_tag !== first_tag) begin
            miscompares++;
            $display("FAIL order_select: valid=%b tag=%0d, need 1/%0d", bus.iss_valid, bus.iss_rob_tag, first_tag);
        end
        push_exp(first_tag, 32'h55, (first_tag == 4'd1) ? 32'd4 : 32'd5, OP_ADD);
        push_exp(second_tag, 32'h55, (second_tag == 4'd1) ? 32'd4 : 32'd5, OP_ADD);
        bus.iss_ready = 1'b1;
        step();
        step();
        vectors++;
        if (bus.occupancy !== 3'd1 || bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL order_left: occ=%0d valid=%b, need 1/0", bus.occupancy, bus.iss_valid);
        end
        set_cdb(4'd14, 32'h77);
        push_exp(4'd11, 32'h77, 32'd3, OP_ADD);
        step();
        idle();
        step();
    endtask

    task automatic test_flush();
        bus.iss_ready = 1'b0;
        set_disp(4'd3, OP_ADD, 32'd1, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0);
        step();
        set_disp(4'd4, OP_ADD, 32'd2, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0);
        step();
        set_disp(4'd5, OP_ADD, 32'd3, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0);
        bus.flush     = 1'b1;
        bus.iss_ready = 1'b1;
        #1;
        vectors++;
        if (bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_suppress: valid=%b, need 0", bus.iss_valid);
        end
        step();
        idle();
        vectors++;
        if (bus.occupancy !== 3'd0 || bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear: occ=%0d valid=%b, need 0/0", bus.occupancy, bus.iss_valid);
        end
    endtask

    task automatic test_reset_mid_queue();
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(TAG_W'(i + 1), OP_ADD, 32'd0, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0);
            step();
        end
        idle();
        vectors++;
        if (bus.occupancy !== 3'd3) begin
            miscompares++;
            $display("FAIL pre_reset_occ: occ=%0d, need 3", bus.occupancy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.occupancy !== 3'd0 || bus.iss_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: occ=%0d valid=%b disp_ready=%b, need 0/0/1",
                     bus.occupancy, bus.iss_valid, bus.disp_ready);
        end
        step();
        rst_n = 1'b1;
        bus.iss_ready = 1'b1;
        set_cdb(4'd15, 32'h99);
        step();
        idle();
        vectors++;
        if (bus.occupancy !== 3'd0 || bus.iss_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: occ=%0d valid=%b, need 0/0", bus.occupancy, bus.iss_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        set_disp('0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        bus.disp_valid = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_value  = '0;
        bus.iss_ready  = 1'b0;
        test_reset();
        test_ready_dispatch();
        test_wakeup();
        test_same_cycle_capture();
        test_full_backpressure();
        test_back_to_back();
        test_ordering();
        test_flush();
        test_reset_mid_queue();
        step();
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL sb_drained: %0d expected issues never seen, need 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..8).
REQ-002 SHALL have parameter TAG_W, default 4, producer-tag width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports disp_valid  input  1 and disp_ready  output  1, the dispatch handshake.
REQ-006 SHALL have ports disp_opcode/disp_funct3/disp_funct7  input  7/3/7, the instruction fields.
REQ-007 SHALL have port disp_rob_tag  input  TAG_W, the destination tag.
REQ-008 SHALL have ports disp_a_val  input  32, disp_a_rdy  input  1 and disp_a_tag  input  TAG_W, for operand A (rs1 or PC); ports disp_b_val, disp_b_rdy and disp_b_tag, identical, for operand B (rs2 or imm).
REQ-009 SHALL have ports cdb_valid  input  1, cdb_tag  input  TAG_W and cdb_value  input  32, the result broadcast.
REQ-010 SHALL have ports iss_valid  output  1 and iss_ready  input  1, the ALU-side handshake.
REQ-011 SHALL have ports iss_val_a/iss_val_b  output  32, iss_opcode/iss_funct3/iss_funct7  output  7/3/7 and iss_rob_tag  output  TAG_W, the payload to the ALU.
REQ-012 SHALL have port flush  input  1, a synchronous squash of all entries.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1), the count of valid entries.

Function
REQ-014 Each entry SHALL hold: valid, opcode, funct3, funct7, rob_tag, and per operand a rdy bit, tag and 32-bit value.
REQ-015 disp_ready SHALL be 1 iff occupancy < DEPTH at the start of the cycle; an entry freed by issue becomes reusable the next cycle.
REQ-016 A dispatch SHALL be accepted when disp_valid&&disp_ready and SHALL write the lowest-index free entry at that edge.
REQ-017 A dispatched operand with rdy=0 whose tag equals cdb_tag while cdb_valid=1 in the same cycle SHALL be written with rdy=1 and cdb_value.
REQ-018 Wakeup: every valid entry operand with rdy=0 and tag==cdb_tag when cdb_valid=1 SHALL capture cdb_value and set rdy at that edge.
REQ-019 An entry SHALL be eligible when valid and both operands rdy; iss_valid SHALL be 1 iff any entry is eligible and flush=0.
REQ-020 The iss_* payload SHALL be combinational from the selected entry; the entry SHALL be freed at the edge where iss_valid&&iss_ready.
REQ-021 While iss_valid=1 and iss_ready=0, the selection SHALL NOT change unless an older entry becomes eligible (REQ-030 ordering).
REQ-022 Minimum latency SHALL be: dispatch with both rdy at edge N gives iss_valid in cycle N+1; CDB wakeup at edge N gives iss_valid in cycle N+1.
REQ-023 Simultaneous dispatch and issue on a full queue SHALL be impossible by REQ-015; on a non-full queue both SHALL complete and occupancy SHALL be unchanged.
REQ-024 flush=1 SHALL invalidate all entries at the edge; flush SHALL override a same-cycle dispatch (dropped) and suppress issue.
REQ-025 cdb_tag matching SHALL be exact over TAG_W bits; a CDB broadcast with no matching entry SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear all valid bits and the age state.
REQ-027 During and after reset: iss_valid=0, disp_ready=1, occupancy=0; iss_* payload SHALL be 0.
REQ-028 Deassertion SHALL take effect at the first clk edge where rst_n=1; no entry state survives reset.

Configuration
REQ-029 Macro ALU_IQ_OLDEST_FIRST_EN SHALL select the issue policy.
REQ-030 With the macro defined, the queue SHALL issue the eligible entry dispatched earliest, tracked by a DEPTH x DEPTH age matrix updated at dispatch/free/flush.
REQ-031 Without the macro, the queue SHALL issue the lowest-index eligible entry and SHALL build no age storage.

Verification
REQ-032 Reset: hold rst_n=0 mid-queue with 3 entries -> occupancy=0, iss_valid=0, disp_ready=1 without waiting for a clock.
REQ-033 Ready dispatch: ADDI, a=5, b=7 both rdy, iss_ready=1 -> next cycle iss_valid=1, iss_val_a=5, iss_val_b=7, opcode=0010011; freed after that edge.
REQ-034 Wakeup: dispatch ADD with a tag=3 (not rdy) and b=2 rdy; 2 cycles later cdb_valid with tag=3, value=0x10 -> iss_valid the next cycle with iss_val_a=0x10.
REQ-035 Same-cycle capture: dispatch with a tag=9 not rdy while cdb tag=9, value=0xAB -> issues next cycle with iss_val_a=0xAB.
REQ-036 Full/backpressure: fill 4 entries, iss_ready=0 -> disp_ready=0 and occupancy=4, payload held stable; on iss_ready=1 for one cycle -> occupancy=3 and disp_ready=1.
REQ-037 Ordering (macro on): dispatch tag 1 into entry 2, then tag 2 into entry 0, both woken the same cycle -> tag 1 issues first; with the macro off -> tag 2 first.
